// File: rtl/block_check_pkg.sv
// Shared types and constants for the begin/end check scheduler.
// Holds the FSM encoding, buffer depth default and the filler character.
package block_check_pkg;

  localparam int BUF_DEPTH_DEFAULT = 16;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_CLR,
    S_PLAY,
    S_TAIL,
    S_SAMPLE,
    S_DONE
  } state_t;

  typedef struct packed {
    logic id;
    logic result;
    logic err;
  } done_t;

endpackage

// File: rtl/block_check_sched_char_buf.sv
// Character store for one session.
// One synchronous write port, one asynchronous read port.
module char_buf #(
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // write accepted characters
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/block_check_sched.sv
// Arbitrates two string requesters, buffers one string,
// replays it into an external begin/end checker and reports.
module block_check_sched
  import block_check_pkg::*;
#(
  parameter int BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       chk_reset,
  output logic [7:0] chk_in,
  input  logic       chk_result,
  output logic       done_valid,
  output logic       done_id,
  output logic       done_result,
  output logic       done_err
);

  localparam int AW =
    (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  state_t state;
  state_t nstate;

  logic [CW-1:0] cnt;
  logic [CW-1:0] k;
  logic          grant;
  logic          last_grant;
  logic          err;
  logic          res_q;
  logic          rst_q;

  logic          any;
  logic          pick;
  logic          sel_valid;
  logic          sel_last;
  logic [7:0]    sel_data;
  logic          take;
  logic          acc;
  logic          full;
  logic          play_end;
  logic          we;
  logic [7:0]    rdata;

  assign any  = req0_valid | req1_valid;
  assign pick = (req0_valid & req1_valid)
              ? ~last_grant : req1_valid;

  assign sel_valid = grant ? req1_valid : req0_valid;
  assign sel_last  = grant ? req1_last  : req0_last;
  assign sel_data  = grant ? req1_data  : req0_data;

  assign take = (state == S_LOAD) | (state == S_DRAIN);
  assign acc  = take & sel_valid;
  assign full = (cnt == CW'(BUF_DEPTH - 1));
  assign we   = (state == S_LOAD) & sel_valid;

  assign play_end = (k == cnt - CW'(1));

  char_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (cnt[AW-1:0]),
    .wdata (sel_data),
    .raddr (k[AW-1:0]),
    .rdata (rdata)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= nstate;
  end

  // next-state selection
  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE:   if (any) nstate = S_LOAD;
      S_LOAD: begin
        if (acc) begin
          if (sel_last)  nstate = S_CLR;
          else if (full) nstate = S_DRAIN;
        end
      end
      S_DRAIN:  if (acc && sel_last) nstate = S_CLR;
      S_CLR:    nstate = S_PLAY;
      S_PLAY:   if (play_end) nstate = S_TAIL;
      S_TAIL:   nstate = S_SAMPLE;
      S_SAMPLE: nstate = S_DONE;
      S_DONE:   nstate = S_IDLE;
      default:  nstate = S_IDLE;
    endcase
  end

  // session datapath: grant, fill count, play index, flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= '0;
      k          <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      err        <= 1'b0;
      res_q      <= 1'b0;
      rst_q      <= 1'b1;
    end else begin
      rst_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          k   <= '0;
          if (any) begin
            grant      <= pick;
            last_grant <= pick;
          end
        end
        S_LOAD: begin
          if (acc) begin
            cnt <= cnt + CW'(1);
            if (!sel_last && full) err <= 1'b1;
          end
        end
        S_CLR:    k     <= '0;
        S_PLAY:   k     <= k + CW'(1);
        S_SAMPLE: res_q <= chk_result;
        S_DONE:   err   <= 1'b0;
        default: ;
      endcase
    end
  end

  // outputs decoded from state
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    chk_reset   = rst_q;
    chk_in      = CHAR_SPACE;
    done_valid  = 1'b0;
    done_id     = 1'b0;
    done_result = 1'b0;
    done_err    = 1'b0;
    unique case (state)
      S_LOAD, S_DRAIN: begin
        req0_ready = ~grant;
        req1_ready = grant;
      end
      S_CLR:  chk_reset = 1'b1;
      S_PLAY: chk_in    = rdata;
      S_DONE: begin
        done_valid  = 1'b1;
        done_id     = grant;
        done_result = res_q;
        done_err    = err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_block_check_sched.sv
// Directed bench for block_check_sched.
// Includes a reference begin/end checker driving chk_result.
module tb_block_check_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_last, req1_last;
  logic       req0_ready, req1_ready;
  logic       chk_reset;
  logic [7:0] chk_in;
  logic       chk_result;
  logic       done_valid, done_id;
  logic       done_result, done_err;

  int checks = 0;
  int failures = 0;

  block_check_sched #(.BUF_DEPTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_last   (req0_last),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_last   (req1_last),
    .req1_ready  (req1_ready),
    .chk_reset   (chk_reset),
    .chk_in      (chk_in),
    .chk_result  (chk_result),
    .done_valid  (done_valid),
    .done_id     (done_id),
    .done_result (done_result),
    .done_err    (done_err)
  );

  always #5 clk = ~clk;

  // reference checker: words separated by spaces,
  // "begin" opens, "end" closes, underflow is sticky bad
  logic [39:0] w = '0;
  int wlen = 0;
  int depth = 0;
  bit bad = 1'b0;

  always @(posedge clk) begin
    if (chk_reset === 1'b1) begin
      depth <= 0;
      bad   <= 1'b0;
      wlen  <= 0;
      w     <= '0;
    end else if (chk_in == 8'h20) begin
      if (wlen == 5 && w == "begin") begin
        depth <= depth + 1;
      end else if (wlen == 3 && w[23:0] == "end") begin
        if (depth == 0) bad <= 1'b1;
        else depth <= depth - 1;
      end
      wlen <= 0;
      w    <= '0;
    end else begin
      w <= {w[31:0], chk_in};
      if (wlen < 8) wlen <= wlen + 1;
    end
  end

  assign chk_result = !bad && (depth == 0);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input bit id, input logic v,
                       input logic [7:0] d,
                       input logic l);
    if (id) begin
      req1_valid = v; req1_data = d; req1_last = l;
    end else begin
      req0_valid = v; req0_data = d; req0_last = l;
    end
  endtask

  task automatic send(input bit id, input string s,
                      input bit gaps, input string tag);
    bit acc;
    for (int i = 0; i < s.len(); i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        drive(id, 1'b0, 8'h00, 1'b0);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      @(negedge clk);
      drive(id, 1'b1, s[i], i == s.len() - 1);
      acc = 1'b0;
      for (int t = 0; t < 400 && !acc; t++) begin
        @(posedge clk);
        acc = id ? req1_ready : req0_ready;
      end
      #1 drive(id, 1'b0, 8'h00, 1'b0);
      if (!acc) begin
        chk({tag, ".accept"}, 32'(acc), 32'd1);
        return;
      end
    end
  endtask

  task automatic wait_done(input int lat, input bit id,
                           input bit res, input bit er,
                           input int nch, input string tag);
    int n = 0;
    int ch = 0;
    int cr = 0;
    bit seen = 1'b0;
    logic cr1 = 1'b0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) cr1 = chk_reset;
      if (chk_reset === 1'b1) cr++;
      if (chk_in !== 8'h20) ch++;
      if (done_valid === 1'b1) begin
        seen = 1'b1;
        n = i;
        chk({tag, ".id"}, 32'(done_id), 32'(id));
        chk({tag, ".result"}, 32'(done_result),
            32'(res));
        chk({tag, ".err"}, 32'(done_err), 32'(er));
      end
    end
    chk({tag, ".latency"}, n, lat);
    chk({tag, ".clr_next"}, 32'(cr1), 32'd1);
    chk({tag, ".clr_pulses"}, cr, 32'd1);
    chk({tag, ".played"}, ch, nch);
    @(negedge clk);
    chk({tag, ".one_shot"}, 32'(done_valid), 32'd0);
  endtask

  initial begin
    int nd;
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ready0", 32'(req0_ready), 32'd0);
    chk("rst.ready1", 32'(req1_ready), 32'd0);
    chk("rst.done", 32'(done_valid), 32'd0);
    chk("rst.chk_reset", 32'(chk_reset), 32'd1);
    chk("rst.chk_in", 32'(chk_in), 32'h20);
    chk("rst.done_id", 32'(done_id), 32'd0);
    reset = 1'b1;

    send(1'b0, "begin end", 1'b0, "t1");
    wait_done(13, 1'b0, 1'b1, 1'b0, 8, "t1");

    send(1'b1, "end begin", 1'b0, "t2");
    wait_done(13, 1'b1, 1'b0, 1'b0, 8, "t2");

    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    fork
      begin
        send(1'b0, "begin end", 1'b0, "t3a");
        wait_done(13, 1'b0, 1'b1, 1'b0, 8, "t3a");
      end
      send(1'b1, "begin end", 1'b0, "t3b");
    join
    wait_done(13, 1'b1, 1'b1, 1'b0, 8, "t3b");

    fork
      begin
        send(1'b0, "begin end begin end ", 1'b0, "t4a");
        wait_done(20, 1'b0, 1'b0, 1'b1, 13, "t4a");
      end
      send(1'b1, "begin end", 1'b0, "t4b");
    join
    wait_done(13, 1'b1, 1'b1, 1'b0, 8, "t4b");

    send(1'b0, "begin end", 1'b0, "t5");
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t5.chk_reset", 32'(chk_reset), 32'd1);
    chk("t5.chk_in", 32'(chk_in), 32'h20);
    chk("t5.ready0", 32'(req0_ready), 32'd0);
    chk("t5.done", 32'(done_valid), 32'd0);
    reset = 1'b1;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_valid === 1'b1) nd++;
    end
    chk("t5.no_done", nd, 0);

    send(1'b0, "begin end", 1'b0, "t6");
    wait_done(13, 1'b0, 1'b1, 1'b0, 8, "t6");

    send(1'b0, "begin end", 1'b1, "t7");
    wait_done(13, 1'b0, 1'b1, 1'b0, 8, "t7");

    send(1'b1, "end begin", 1'b1, "t8");
    wait_done(13, 1'b1, 1'b0, 1'b0, 8, "t8");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/block_check_sched.md
BLOCK_CHECK_SCHED -- requirements
Module: block_check_sched

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 16, max characters buffered per session.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  requester has a character beat.
REQ-005 SHALL have ports req0_data/req1_data  input  8  ASCII character.
REQ-006 SHALL have ports req0_last/req1_last  input  1  beat is last character of the string.
REQ-007 SHALL have ports req0_ready/req1_ready  output  1  beat accepted when valid&ready.
REQ-008 SHALL have port chk_reset  output  1  active-high reset to the begin/end checker.
REQ-009 SHALL have port chk_in  output  8  character driven to the checker, one per clock.
REQ-010 SHALL have port chk_result  input  1  checker balanced/valid result.
REQ-011 SHALL have ports done_valid  output  1; done_id  output  1; done_result  output  1; done_err  output  1  one-cycle session report.

Function
REQ-012 SHALL implement FSM IDLE, LOAD, DRAIN, CLR, PLAY, TAIL, SAMPLE, DONE.
REQ-013 IDLE: if any valid, grant round-robin (requester not granted last wins a tie), then go to LOAD next cycle; ready low in IDLE.
REQ-014 LOAD: only the granted requester's ready SHALL be 1; each accepted beat writes buffer[cnt] and increments cnt; gaps in valid are tolerated.
REQ-015 LOAD: an accepted beat with last=1 SHALL go to CLR; an accepted BUF_DEPTH-th beat with last=0 SHALL set err and go to DRAIN.
REQ-016 DRAIN: granted ready=1, beats discarded, go to CLR on the accepted last beat.
REQ-017 CLR: chk_reset=1 for exactly one cycle; chk_reset=0 in all other non-reset cycles.
REQ-018 PLAY: chk_in=buffer[k] for k=0..len-1 on consecutive cycles, no bubbles.
REQ-019 TAIL: chk_in=8'h20 (space) for one cycle to terminate the final word.
REQ-020 SAMPLE: capture chk_result; DONE: done_valid=1 for one cycle with done_id=grant, done_result=captured value, done_err=err; then IDLE.
REQ-021 chk_in SHALL be 8'h20 in every state other than PLAY.
REQ-022 Latency: last beat accepted in cycle t, non-truncated length N -> CLR t+1, PLAY t+2..t+N+1, TAIL t+N+2, SAMPLE t+N+3, done_valid t+N+4.
REQ-023 Truncated session SHALL play exactly BUF_DEPTH characters; latency counted from the drained last beat.
REQ-024 cnt SHALL be wide enough to hold BUF_DEPTH without wrap; err cleared on leaving DONE.
REQ-025 Valid on the non-granted requester during a session SHALL be ignored (ready held 0).

Reset
REQ-026 reset=0 at a clock edge SHALL force IDLE, cnt=0, err=0, last-grant=1 (req0 wins first), all ready=0, done_*=0, chk_reset=1, chk_in=8'h20.
REQ-027 Reset mid-session SHALL abandon the session with no done_valid; the next session SHALL behave as after power-up.

Structure
REQ-028 Package block_check_pkg SHALL hold the state enum, BUF_DEPTH default, and CHAR_SPACE=8'h20.
REQ-029 Character storage SHALL be a sub-module char_buf (BUF_DEPTH x 8, one write port, one read port); the checker stays external.

Verification
REQ-030 req0 sends "begin end" (9 beats, last on 'd') -> done_valid 13 cycles after last beat, done_id=0, done_result=1, done_err=0.
REQ-031 req1 sends "end begin" -> done_id=1, done_result=0.
REQ-032 Both valid in first IDLE after reset, each sends "begin end" -> req0 served first, then req1; done_id sequence 0,1.
REQ-033 req0 sends 20-char string -> 16 chars played, chars 17-20 accepted and dropped, done_err=1, next grant to req1 if it is valid.
REQ-034 reset low during PLAY -> next cycle IDLE, chk_reset=1, no done_valid; following "begin end" returns done_result=1.
REQ-035 req0 "begin end" with random valid gaps -> identical result, done_valid still 13 cycles after last beat.
